// File: rtl/dsr_align_ctrl.sv
// Deserializer word-alignment controller: DSR reset, training-pattern check, bit-slip search, lock monitor.
// Build macro DSR_ALIGN_TMR_EN triplicates every register behind majority voters.
module dsr_align_ctrl #(
    parameter int unsigned   DW        = 8,
    parameter logic [DW-1:0] TRAIN_PAT = 8'hA5,
    parameter int unsigned   RST_CYC   = 5,
    parameter int unsigned   WAIT_CYC  = 4,
    parameter int unsigned   MATCH_CNT = 4,
    parameter int unsigned   SLIP_MAX  = 8,
    parameter int unsigned   LOSS_CNT  = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_realign,
    input  logic [DW-1:0] i_din,
    output logic          o_aligned,
    output logic          o_bit_slip_evn,
    output logic          o_bit_slip_odd,
    output logic          o_dsr_rst,
    output logic          o_strt_pipe,
    output logic          o_align_err,
    output logic [3:0]    o_slip_cnt,
    output logic          o_odd_ph
);

    typedef enum logic [3:0] {
        S_START, S_DSR_RST, S_WRST, S_WAIT, S_CHECK,
        S_SLIP, S_SLIPODD, S_RESTART, S_ALIGNED, S_FAIL
    } state_t;

    typedef struct packed {
        logic aligned;
        logic slip_evn;
        logic slip_odd;
        logic dsr_rst;
        logic strt_pipe;
        logic align_err;
    } outs_t;

    localparam logic [3:0] L_RST_LAST   = 4'(RST_CYC - 1);
    localparam logic [3:0] L_WAIT_LAST  = 4'(WAIT_CYC - 1);
    localparam logic [3:0] L_MATCH_LAST = 4'(MATCH_CNT - 1);
    localparam logic [3:0] L_SLIP_MAX   = 4'(SLIP_MAX);
    localparam logic [3:0] L_LOSS_LAST  = 4'((LOSS_CNT == 0) ? 0 : LOSS_CNT - 1);
    localparam bit         L_LOSS_EN    = (LOSS_CNT != 0);

`ifdef DSR_ALIGN_TMR_EN
    localparam int NCOPY = 3;
`else
    localparam int NCOPY = 1;
`endif

    logic [3:0] r_state     [NCOPY];
    logic [3:0] r_slip_cnt  [NCOPY];
    logic       r_odd_ph    [NCOPY];
    logic [3:0] r_match_cnt [NCOPY];
    logic [3:0] r_loss_cnt  [NCOPY];
    logic [3:0] r_wait_cnt  [NCOPY];
    outs_t      r_outs      [NCOPY];

    state_t     w_state;
    logic [3:0] w_slip_cnt, w_match_cnt, w_loss_cnt, w_wait_cnt;
    logic       w_odd_ph;
    outs_t      w_outs;

    state_t     w_nxt_state;
    logic [3:0] w_nxt_slip, w_nxt_match, w_nxt_loss, w_nxt_wait;
    logic       w_nxt_odd;
    logic       w_match;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Outputs are a pure function of the state being entered.
    function automatic outs_t decode(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_DSR_RST: o.dsr_rst   = 1'b1;
            S_SLIP:    begin o.slip_evn = 1'b1; o.slip_odd = 1'b1; end
            S_SLIPODD: o.slip_odd  = 1'b1;
            S_RESTART: o.strt_pipe = 1'b1;
            S_ALIGNED: o.aligned   = 1'b1;
            S_FAIL:    o.align_err = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

`ifdef DSR_ALIGN_TMR_EN
    function automatic logic [3:0] maj4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [5:0] maj6(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_comb begin
        w_state     = state_t'(maj4(r_state[0], r_state[1], r_state[2]));
        w_slip_cnt  = maj4(r_slip_cnt[0], r_slip_cnt[1], r_slip_cnt[2]);
        w_match_cnt = maj4(r_match_cnt[0], r_match_cnt[1], r_match_cnt[2]);
        w_loss_cnt  = maj4(r_loss_cnt[0], r_loss_cnt[1], r_loss_cnt[2]);
        w_wait_cnt  = maj4(r_wait_cnt[0], r_wait_cnt[1], r_wait_cnt[2]);
        w_odd_ph    = (r_odd_ph[0] & r_odd_ph[1]) | (r_odd_ph[0] & r_odd_ph[2]) | (r_odd_ph[1] & r_odd_ph[2]);
        w_outs      = outs_t'(maj6(r_outs[0], r_outs[1], r_outs[2]));
    end
`else
    assign w_state     = state_t'(r_state[0]);
    assign w_slip_cnt  = r_slip_cnt[0];
    assign w_match_cnt = r_match_cnt[0];
    assign w_loss_cnt  = r_loss_cnt[0];
    assign w_wait_cnt  = r_wait_cnt[0];
    assign w_odd_ph    = r_odd_ph[0];
    assign w_outs      = r_outs[0];
`endif

    assign w_match = (i_din == TRAIN_PAT);

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can leave one unassigned and infer a latch.
        w_nxt_state = w_state;
        w_nxt_slip  = w_slip_cnt;
        w_nxt_odd   = w_odd_ph;
        w_nxt_match = w_match_cnt;
        w_nxt_loss  = w_loss_cnt;
        w_nxt_wait  = w_wait_cnt;
        if (i_realign && (w_state != S_START) && (w_state != S_DSR_RST)) begin
            w_nxt_state = S_DSR_RST;
            w_nxt_slip  = '0;
            w_nxt_odd   = 1'b0;
            w_nxt_match = '0;
            w_nxt_loss  = '0;
            w_nxt_wait  = '0;
        end else begin
            case (w_state)
                S_START: begin
                    w_nxt_state = S_DSR_RST;
                    w_nxt_wait  = '0;
                end
                S_DSR_RST: begin
                    if (w_wait_cnt >= L_RST_LAST) begin
                        w_nxt_state = S_WRST;
                        w_nxt_wait  = '0;
                    end else begin
                        w_nxt_wait = sat_inc(w_wait_cnt);
                    end
                end
                S_WRST: begin
                    w_nxt_state = S_WAIT;
                    w_nxt_wait  = '0;
                end
                S_WAIT: begin
                    if (w_wait_cnt >= L_WAIT_LAST) begin
                        w_nxt_state = S_CHECK;
                        w_nxt_wait  = '0;
                        w_nxt_match = '0;
                    end else begin
                        w_nxt_wait = sat_inc(w_wait_cnt);
                    end
                end
                S_CHECK: begin
                    if (w_match) begin
                        if (w_match_cnt >= L_MATCH_LAST) begin
                            w_nxt_state = S_RESTART;
                            w_nxt_match = '0;
                        end else begin
                            w_nxt_match = sat_inc(w_match_cnt);
                        end
                    end else begin
                        w_nxt_match = '0;
                        if (w_slip_cnt < L_SLIP_MAX) begin
                            w_nxt_state = S_SLIP;
                            w_nxt_slip  = sat_inc(w_slip_cnt);
                        end else if (!w_odd_ph) begin
                            w_nxt_state = S_SLIPODD;
                            w_nxt_odd   = 1'b1;
                            w_nxt_slip  = '0;
                        end else begin
                            w_nxt_state = S_FAIL;
                        end
                    end
                end
                S_SLIP, S_SLIPODD: begin
                    w_nxt_state = S_WAIT;
                    w_nxt_wait  = '0;
                end
                S_RESTART: begin
                    w_nxt_state = S_ALIGNED;
                    w_nxt_loss  = '0;
                end
                S_ALIGNED: begin
                    if (w_match) begin
                        w_nxt_loss = '0;
                    end else if (L_LOSS_EN) begin
                        if (w_loss_cnt >= L_LOSS_LAST) begin
                            w_nxt_state = S_DSR_RST;
                            w_nxt_slip  = '0;
                            w_nxt_odd   = 1'b0;
                            w_nxt_match = '0;
                            w_nxt_loss  = '0;
                            w_nxt_wait  = '0;
                        end else begin
                            w_nxt_loss = sat_inc(w_loss_cnt);
                        end
                    end
                end
                S_FAIL: w_nxt_state = S_FAIL;
                default: begin
                    w_nxt_state = S_START;
                    w_nxt_wait  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NCOPY; k++) begin
            if (i_rst) begin
                r_state[k]     <= S_START;
                r_slip_cnt[k]  <= '0;
                r_odd_ph[k]    <= 1'b0;
                r_match_cnt[k] <= '0;
                r_loss_cnt[k]  <= '0;
                r_wait_cnt[k]  <= '0;
                r_outs[k]      <= '0;
            end else begin
                // NOTE: each copy reloads from the voted next value, so an upset copy is rewritten on the next edge.
                r_state[k]     <= w_nxt_state;
                r_slip_cnt[k]  <= w_nxt_slip;
                r_odd_ph[k]    <= w_nxt_odd;
                r_match_cnt[k] <= w_nxt_match;
                r_loss_cnt[k]  <= w_nxt_loss;
                r_wait_cnt[k]  <= w_nxt_wait;
                r_outs[k]      <= decode(w_nxt_state);
            end
        end
    end

    assign o_aligned      = w_outs.aligned;
    assign o_bit_slip_evn = w_outs.slip_evn;
    assign o_bit_slip_odd = w_outs.slip_odd;
    assign o_dsr_rst      = w_outs.dsr_rst;
    assign o_strt_pipe    = w_outs.strt_pipe;
    assign o_align_err    = w_outs.align_err;
    assign o_slip_cnt     = w_slip_cnt;
    assign o_odd_ph       = w_odd_ph;

endmodule

// File: tb/tb_dsr_align_ctrl.sv
// Self-checking bench for dsr_align_ctrl: edge-exact vector table, bit-offset channel model,
// search/loss reference model, reset and realign corner sequences.
module tb_dsr_align_ctrl;

    localparam logic [7:0] PAT  = 8'hA5;
    localparam int         LOSS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       realign = 1'b0;
    logic [7:0] din;
    logic       o_aligned, o_bit_slip_evn, o_bit_slip_odd, o_dsr_rst, o_strt_pipe, o_align_err, o_odd_ph;
    logic [3:0] o_slip_cnt;
    logic [5:0] flags;

    dsr_align_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_realign      (realign),
        .i_din          (din),
        .o_aligned      (o_aligned),
        .o_bit_slip_evn (o_bit_slip_evn),
        .o_bit_slip_odd (o_bit_slip_odd),
        .o_dsr_rst      (o_dsr_rst),
        .o_strt_pipe    (o_strt_pipe),
        .o_align_err    (o_align_err),
        .o_slip_cnt     (o_slip_cnt),
        .o_odd_ph       (o_odd_ph)
    );

    always #5 clk = ~clk;

    assign flags = {o_aligned, o_bit_slip_evn, o_bit_slip_odd, o_dsr_rst, o_strt_pipe, o_align_err};

    // Channel model: the DSR sits 'off' bits away from word alignment.
    int         off = 0;
    bit         force_en = 1'b0;
    logic [7:0] force_word = 8'h00;

    function automatic logic [7:0] rot(input int o);
        logic [15:0] d;
        d = {PAT, PAT};
        d = d >> (8 - o);
        return d[7:0];
    endfunction

    always_comb din = force_en ? force_word : rot(off);

    int         n_vec = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         n_pair, n_odd, n_bad, strt_edge;
    logic [3:0] odd_sc;
    logic       odd_ph_at;

    typedef struct {
        logic       realign;
        logic [7:0] din;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [37];

    typedef struct {
        int   pair;
        int   odd;
        int   sc;
        logic oph;
    } lock_exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_bit_slip_evn && o_bit_slip_odd) begin
            n_pair++;
            off = (off + 6) % 8;
        end else if (o_bit_slip_odd) begin
            n_odd++;
            off = (off + 7) % 8;
            odd_sc = o_slip_cnt;
            odd_ph_at = o_odd_ph;
        end else if (o_bit_slip_evn) begin
            n_bad++;
        end
        if (o_strt_pipe) strt_edge = cyc;
    endtask

    task automatic do_reset(input string name, input int start_off, input bit fz, input logic [7:0] fw);
        rst = 1'b1;
        realign = 1'b0;
        off = start_off;
        force_en = fz;
        force_word = fw;
        tick();
        check({name, " reset outputs"}, {21'd0, flags, o_odd_ph, o_slip_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        cyc = 0;
        n_pair = 0;
        n_odd = 0;
        n_bad = 0;
        strt_edge = -1;
    endtask

    task automatic run_until(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = o_strt_pipe | o_align_err;
        end
    endtask

    // A paired slip moves the word 2 bits, the odd step 1 bit. Even offsets close with
    // paired slips only; odd ones burn a full phase (8 pairs = 16 bits, back to start),
    // take the odd step, then close the remaining even offset.
    function automatic lock_exp_t lock_model(input int o);
        lock_exp_t m;
        if (o % 2 == 0) begin
            m.pair = o / 2; m.odd = 0; m.sc = o / 2; m.oph = 1'b0;
        end else begin
            m.pair = 8 + (o - 1) / 2; m.odd = 1; m.sc = (o - 1) / 2; m.oph = 1'b1;
        end
        return m;
    endfunction

    task automatic lock_test(input string name, input int start_off);
        lock_exp_t m;
        logic      got;
        m = lock_model(start_off);
        do_reset(name, start_off, 1'b0, 8'h00);
        run_until(400, got);
        check({name, " strt_pipe"}, o_strt_pipe, 1);
        check({name, " paired slips"}, n_pair, m.pair);
        check({name, " odd slips"}, n_odd, m.odd);
        check({name, " even-only pulses"}, n_bad, 0);
        // CHECK entered at edge 11, each slip round costs 6 edges, 4 matches then restart.
        check({name, " strt edge"}, strt_edge, 15 + 6 * (m.pair + m.odd));
        check({name, " slip_cnt"}, o_slip_cnt, m.sc);
        check({name, " odd_ph"}, o_odd_ph, m.oph);
        if (m.odd != 0) begin
            check({name, " slip_cnt at odd step"}, odd_sc, 0);
            check({name, " odd_ph at odd step"}, odd_ph_at, 1);
        end
        tick();
        check({name, " aligned after restart"}, flags, 6'b100000);
    endtask

    function automatic logic [7:0] bad_word();
        logic [7:0] w;
        do w = 8'($urandom); while (w == PAT);
        return w;
    endfunction

    task automatic loss_test(input string name, input bit mism [$]);
        int run;
        bit drop;
        run = 0;
        drop = 1'b0;
        force_en = 1'b1;
        foreach (mism[i]) begin
            if (!drop) begin
                force_word = mism[i] ? bad_word() : PAT;
                tick();
                run = mism[i] ? run + 1 : 0;
                drop = (run >= LOSS);
                check($sformatf("%s aligned at word %0d", name, i), o_aligned, !drop);
                if (drop) check($sformatf("%s dsr_rst at drop", name), o_dsr_rst, 1);
            end
        end
        force_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic got;
        bit   q [$];

        // Edge-exact table: realign ignored in DSR_RST (edge 3), wins over the lock
        // decision at edge 15, and restarts from ALIGNED at edge 32.
        for (int e = 1; e <= 37; e++) begin
            vecs[e-1].realign = (e == 3) || (e == 15) || (e == 32);
            vecs[e-1].din     = PAT;
            vecs[e-1].exp     = '0;
            if ((e <= 5) || (e >= 15 && e <= 19) || (e >= 32 && e <= 36)) vecs[e-1].exp[2] = 1'b1;
            if (e == 29) vecs[e-1].exp[1] = 1'b1;
            if (e == 30 || e == 31) vecs[e-1].exp[5] = 1'b1;
        end

        do_reset("table", 0, 1'b1, PAT);
        for (int i = 0; i < 37; i++) begin
            realign = vecs[i].realign;
            force_word = vecs[i].din;
            tick();
            realign = 1'b0;
            check($sformatf("table edge %0d", i + 1), flags, vecs[i].exp);
        end
        force_en = 1'b0;

        lock_test("immediate lock", 0);
        lock_test("offset 4", 4);
        lock_test("offset 1", 1);

        do_reset("no lock", 0, 1'b1, 8'h00);
        run_until(400, got);
        check("no lock align_err", o_align_err, 1);
        check("no lock paired slips", n_pair, 16);
        check("no lock odd slips", n_odd, 1);
        // 18th mismatch: samples at 12 + 6k, k = 17.
        check("no lock err edge", cyc, 12 + 6 * 17);
        check("no lock slip_cnt", o_slip_cnt, 8);
        check("no lock odd_ph", o_odd_ph, 1);
        repeat (5) tick();
        check("align_err sticky", flags, 6'b000001);
        check("no slips while stuck", n_pair + n_odd, 17);
        realign = 1'b1;
        tick();
        realign = 1'b0;
        check("realign from error flags", flags, 6'b000100);
        check("realign slip_cnt", o_slip_cnt, 0);
        check("realign odd_ph", o_odd_ph, 0);

        lock_test("loss base", 0);
        for (int i = 0; i < 7; i++) q.push_back(1'b1);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(1'b1);
        loss_test("loss 7-1-8", q);
        check("loss dropped", o_aligned, 0);

        do_reset("pre mid-slip", 4, 1'b0, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            got = o_bit_slip_evn;
        end
        check("mid-slip reached", got, 1);
        lock_test("rst mid-slip", off);

        do_reset("pre mid-restart", 0, 1'b0, 8'h00);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            got = o_strt_pipe;
        end
        check("mid-restart reached", got, 1);
        lock_test("rst mid-restart", off);

`ifdef DSR_ALIGN_TMR_EN
        begin
            logic [5:0] before;
            lock_test("tmr base", 0);
            before = flags;
            dut.r_state[1] = dut.r_state[1] ^ 4'h3;
            tick();
            check("tmr state upset", flags, before);
            tick();
            check("tmr after scrub", flags, before);
        end
`endif

        for (int r = 0; r < 6; r++) begin
            int o;
            o = int'($urandom_range(7, 0));
            lock_test($sformatf("random off %0d", o), o);
            q.delete();
            for (int i = 0; i < 30; i++) q.push_back($urandom_range(3, 0) != 0);
            loss_test($sformatf("random loss %0d", r), q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
